// File: rtl/aes_pkg.sv
// AES shared constants: word/byte widths
// and the forward S-box lookup table.
package aes_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b,
    8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b,
    8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d,
    8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf,
    8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26,
    8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1,
    8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3,
    8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2,
    8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a,
    8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3,
    8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed,
    8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39,
    8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb,
    8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f,
    8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f,
    8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21,
    8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec,
    8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d,
    8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc,
    8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14,
    8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a,
    8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62,
    8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d,
    8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea,
    8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e,
    8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f,
    8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66,
    8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9,
    8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11,
    8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9,
    8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d,
    8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f,
    8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte forward S-box: pure
// combinational table lookup.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] byte_o
);

  // Table lookup, total over 0..255
  always_comb begin
    byte_o = SBOX[byte_i];
  end

endmodule

// File: rtl/sub_word.sv
// AES SubWord: four parallel S-box lookups
// with a registered output and valid flag.
module sub_word
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word
);

  logic [WORD_W-1:0] sub_w;
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;
  logic              valid_d;
  logic              valid_q;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox_byte u_sbox (
      .byte_i (in_word[i*BYTE_W +: BYTE_W]),
      .byte_o (sub_w[i*BYTE_W +: BYTE_W])
    );
  end

  // Capture only valid words; hold otherwise
  always_comb begin
    word_d  = word_q;
    valid_d = in_valid;
    if (in_valid) begin
      word_d = sub_w;
    end
  end

  // Output stage; reset drops any word
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign out_word  = word_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sub_word.sv
// Self-checking bench for sub_word against
// a GF(2^8) inverse + affine S-box model.
module tb_sub_word;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_valid;
  logic [31:0] out_word;

  int checks;
  int errors;

  logic [31:0] m_word;
  logic        m_valid;

  sub_word dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_word  (out_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S(b) = affine(b^254); 0 maps to 0 first
  function automatic logic [7:0] sbox_ref(
    input logic [7:0] b
  );
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < 254; k++) begin
      r = gmul(r, b);
    end
    if (b == 8'h00) r = 8'h00;
    return r
      ^ {r[6:0], r[7]}
      ^ {r[5:0], r[7:6]}
      ^ {r[4:0], r[7:5]}
      ^ {r[3:0], r[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [31:0] word_ref(
    input logic [31:0] w
  );
    return {sbox_ref(w[31:24]),
            sbox_ref(w[23:16]),
            sbox_ref(w[15:8]),
            sbox_ref(w[7:0])};
  endfunction

  // Drive one cycle and advance the model
  task automatic cyc(
    input logic        r,
    input logic        v,
    input logic [31:0] w
  );
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_word  = w;
    @(posedge clk);
    #1;
    if (r) begin
      m_word  = 32'h0;
      m_valid = 1'b0;
    end else begin
      m_valid = v;
      if (v) m_word = word_ref(w);
    end
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 32'hffff_ffff);
    checks++;
    if (out_word !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: got %h/%b want 00000000/0",
               out_word, out_valid);
    end
  endtask

  task automatic test_fips_vector();
    cyc(1'b0, 1'b1, 32'hcf4f_3c09);
    checks++;
    if (out_word !== 32'h8a84_eb01 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fips_vec: got %h/%b want 8a84eb01/1",
               out_word, out_valid);
    end
  endtask

  task automatic test_byte_indep();
    cyc(1'b0, 1'b1, 32'h0001_5310);
    checks++;
    if (out_word !== 32'h637c_edca || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL byte_indep: got %h/%b want 637cedca/1",
               out_word, out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  b;
    logic [7:0]  s;
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      w = {b, b, b, b};
      cyc(1'b0, 1'b1, w);
      s = sbox_ref(b);
      checks++;
      if (out_word !== {s, s, s, s} || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep b=%h: got %h/%b want %h/1",
                 b, out_word, out_valid, {s, s, s, s});
      end
      if (b == 8'hff) begin
        checks++;
        if (out_word !== 32'h1616_1616) begin
          errors++;
          $display("FAIL sweep_ff: got %h want 16161616",
                   out_word);
        end
      end
    end
  endtask

  task automatic test_valid_gating();
    cyc(1'b0, 1'b1, 32'h8a84_eb01);
    checks++;
    if (out_word !== m_word || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL gate_on: got %h/%b want %h/1",
               out_word, out_valid, m_word);
    end
    cyc(1'b0, 1'b0, 32'h0000_0000);
    checks++;
    if (out_word !== word_ref(32'h8a84_eb01)
        || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gate_off: got %h/%b want %h/0",
               out_word, out_valid,
               word_ref(32'h8a84_eb01));
    end
    checks++;
    if (out_word === 32'h6363_6363) begin
      errors++;
      $display("FAIL gate_leak: got %h want held value",
               out_word);
    end
  endtask

  task automatic test_reset_midstream();
    cyc(1'b0, 1'b1, 32'hffff_ffff);
    checks++;
    if (out_word !== 32'h1616_1616 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_first: got %h/%b want 16161616/1",
               out_word, out_valid);
    end
    cyc(1'b1, 1'b1, 32'h0000_0000);
    checks++;
    if (out_word !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got %h/%b want 00000000/0",
               out_word, out_valid);
    end
    cyc(1'b0, 1'b0, 32'h1234_5678);
    checks++;
    if (out_word !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got %h/%b want 00000000/0",
               out_word, out_valid);
    end
    cyc(1'b0, 1'b1, 32'h0101_0101);
    checks++;
    if (out_word !== 32'h7c7c_7c7c || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_resume: got %h/%b want 7c7c7c7c/1",
               out_word, out_valid);
    end
  endtask

  task automatic test_random();
    logic        r;
    logic        v;
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(15) == 0);
      v = $urandom_range(1) == 1;
      w = $urandom;
      cyc(r, v, w);
      checks++;
      if (out_word !== m_word || out_valid !== m_valid) begin
        errors++;
        $display("FAIL random #%0d: got %h/%b want %h/%b",
                 i, out_word, out_valid, m_word, m_valid);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    m_word   = 32'h0;
    m_valid  = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_word  = 32'h0;
    test_reset();
    test_fips_vector();
    test_byte_indep();
    test_sweep();
    test_valid_gating();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
